sr_latch_sequencer: RTL and testbench



---
 rtl/sr_latch_sequencer.sv | 165 ++++++++++++++++
 tb/tb_sr_latch_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_sequencer.sv
// Round-robin sequencer that shares one SR latch between N requesters.
// Drives a fixed-width S or R pulse, an all-low gap, then checks the latch output.
module sr_latch_sequencer #(
  parameter int N       = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_op,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] sel_id,
  output logic           S,
  output logic           R,
  input  logic           q_fb,
  output logic           busy,
  output logic           done,
  output logic           err
);

  // state    | meaning
  // IDLE     | waiting for a request; arbitration happens only here
  // DRIVE    | S or R held high for PULSE_W cycles
  // GAP      | S=R=0 for GAP_W cycles; q_fb sampled at the edge ending the last one
  // CHECK    | one cycle presenting done or err
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W - 1);

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           op_q, op_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] sel_q, sel_d;
  logic           s_q, s_d;
  logic           r_q, r_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           arb_found;
  logic [IDW-1:0] arb_win;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return IDW'(s);
  endfunction

  // First requesting index at or after ptr, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    for (int k = 0; k < N; k++) begin
      if (!arb_found && req[rr_idx(ptr_q, k)]) begin
        arb_found = 1'b1;
        arb_win   = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    gnt_d   = '0;
    sel_d   = sel_q;
    s_d     = s_q;
    r_d     = r_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          state_d        = ST_DRIVE;
          gnt_d[arb_win] = 1'b1;
          sel_d          = arb_win;
          op_d           = req_op[arb_win];
          s_d            = req_op[arb_win];
          r_d            = ~req_op[arb_win];
          ptr_d          = rr_idx(arb_win, 1);
          cnt_d          = PULSE_LD;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          s_d     = 1'b0;
          r_d     = 1'b0;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_CHECK;
          done_d  = (q_fb == op_q);
          err_d   = (q_fb != op_q);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      gnt_q   <= '0;
      sel_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign gnt    = gnt_q;
  assign sel_id = sel_q;
  assign S      = s_q;
  assign R      = r_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Bench for sr_latch_sequencer (N=4, PULSE_W=2, GAP_W=1) with a behavioural SR latch.
// Each vector row gives inputs for one cycle and the outputs required in the following cycle.
module tb_sr_latch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_op;
  logic [3:0] gnt;
  logic [1:0] sel_id;
  logic       S, R, q_fb, busy, done, err;

  logic       q_lat = 1'b0;
  logic       stuck = 1'b0;
  bit         mon_on = 1'b0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  sr_latch_sequencer #(.N(4), .PULSE_W(2), .GAP_W(1), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .gnt(gnt), .sel_id(sel_id),
    .S(S), .R(R), .q_fb(q_fb), .busy(busy), .done(done), .err(err)
  );

  // Latch model; stuck forces Q low to emulate a broken latch.
  always @(posedge clk) begin
    if (S) q_lat <= 1'b1;
    else if (R) q_lat <= 1'b0;
  end
  assign q_fb = stuck ? 1'b0 : q_lat;

  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if ((S & R) !== 1'b0) begin
        bad++;
        $display("FAIL s_and_r: got S=%b R=%b want S&R=0 (t=%0t)", S, R, $time);
      end
    end
  end

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] op;
    logic       stuck;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       s;
    logic       r;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic rst_i, logic [3:0] req_i, logic [3:0] op_i, logic stuck_i,
                              logic [3:0] g, logic [1:0] sel, logic s, logic r,
                              logic b, logic d, logic e);
    vec_t v;
    v.rst = rst_i; v.req = req_i; v.op = op_i; v.stuck = stuck_i;
    v.gnt = g; v.sel = sel; v.s = s; v.r = r; v.busy = b; v.done = d; v.err = e;
    return v;
  endfunction

  task automatic add_reset();
    tbl.push_back(mk(1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Continuous-load stream: grants every 5 cycles to first, first+1, ... modulo period.
  task automatic add_stream(input logic [3:0] rq, input logic [3:0] op,
                            input int first, input int period, input int ntrans);
    for (int k = 0; k < 5 * ntrans; k++) begin
      int         ph;
      int         id;
      logic       a;
      logic [3:0] g;
      logic [1:0] sl;
      ph = k % 5;
      id = first + (k / 5) % period;
      a  = op[id];
      g  = 4'(1 << id);
      sl = 2'(id);
      case (ph)
        0: tbl.push_back(mk(1'b0, rq, op, 1'b0, g,    sl, a,    ~a,   1'b1, 1'b0, 1'b0));
        1: tbl.push_back(mk(1'b0, rq, op, 1'b0, 4'b0, sl, a,    ~a,   1'b1, 1'b0, 1'b0));
        2: tbl.push_back(mk(1'b0, rq, op, 1'b0, 4'b0, sl, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        3: tbl.push_back(mk(1'b0, rq, op, 1'b0, 4'b0, sl, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        default: tbl.push_back(mk(1'b0, rq, op, 1'b0, 4'b0, sl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      endcase
    end
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0h want %0h (t=%0t)", nm, row, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input int row);
    vec_t e;
    @(negedge clk);
    rst    = v.rst;
    req    = v.req;
    req_op = v.op;
    stuck  = v.stuck;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("gnt",    row, 32'(gnt),    32'(e.gnt));
    chk("sel_id", row, 32'(sel_id), 32'(e.sel));
    chk("S",      row, 32'(S),      32'(e.s));
    chk("R",      row, 32'(R),      32'(e.r));
    chk("busy",   row, 32'(busy),   32'(e.busy));
    chk("done",   row, 32'(done),   32'(e.done));
    chk("err",    row, 32'(err),    32'(e.err));
  endtask

  initial begin
    rst    = 1'b1;
    req    = 4'b0;
    req_op = 4'b0;

    // reset state
    add_reset();
    add_reset();
    // single set, good latch
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 4'b0001, 2'd0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 4'b0000, 2'd0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0, 0, 0));
    // failing latch: Q stuck low on a set
    add_reset();
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 1, 4'b0001, 2'd0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0001, 1, 4'b0000, 2'd0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, 0, 0, 0));
    // fairness: all four held, mixed ops
    add_reset();
    add_stream(4'b1111, 4'b0101, 0, 4, 5);
    // alternating: 1 sets, 2 resets
    add_reset();
    add_stream(4'b0110, 4'b0010, 1, 2, 4);
    // reset mid-drive, then 0101 must go to requester 0 first
    add_reset();
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 4'b0001, 2'd0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0001, 0, 4'b0000, 2'd0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0001, 0, 4'b0000, 2'd0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0101, 0, 4'b0001, 2'd0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0101, 0, 4'b0000, 2'd0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0101, 0, 4'b0000, 2'd0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0101, 0, 4'b0000, 2'd0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0101, 0, 4'b0000, 2'd0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0101, 0, 4'b0100, 2'd2, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0101, 0, 4'b0000, 2'd2, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0101, 0, 4'b0000, 2'd2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0101, 0, 4'b0000, 2'd2, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0101, 0, 4'b0000, 2'd2, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
      mon_on = 1'b1;
    end

    // req_op flipped in cycle 2 after a set grant: check still against captured op
    apply(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0, 0, 0), 1000);
    apply(mk(0, 4'b0001, 4'b0001, 0, 4'b0001, 2'd0, 1, 0, 1, 0, 0), 1001);
    apply(mk(0, 4'b0000, 4'b0001, 0, 4'b0000, 2'd0, 1, 0, 1, 0, 0), 1002);
    apply(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 1, 0, 0), 1003);
    apply(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 1, 1, 0), 1004);
    apply(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0, 0, 0), 1005);

    // reset op, flipped to set during cycle 1: R must stay, latch cleared, done expected
    apply(mk(0, 4'b1000, 4'b0000, 0, 4'b0001 << 3, 2'd3, 0, 1, 1, 0, 0), 1006);
    apply(mk(0, 4'b0000, 4'b1000, 0, 4'b0000, 2'd3, 0, 1, 1, 0, 0), 1007);
    apply(mk(0, 4'b0000, 4'b1000, 0, 4'b0000, 2'd3, 0, 0, 1, 0, 0), 1008);
    apply(mk(0, 4'b0000, 4'b1000, 0, 4'b0000, 2'd3, 0, 0, 1, 1, 0), 1009);
    apply(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd3, 0, 0, 0, 0, 0), 1010);

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
